// File: rtl/sram_sp.sv
// Single-port storage array for the FIFO datapath.
// Synchronous write, combinational read, async clear.
module sram_sp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  logic  in_range;

  generate
    if (DEPTH < 2 || DATA_WIDTH < 1) begin : g_param_chk
      $error("sram_sp: DEPTH must be >= 2 and DATA_WIDTH >= 1");
    end
  endgenerate

  // Addresses past the last word only exist for non-power-of-two depths
  assign in_range = ({1'b0, addr_i} < (ADDR_WIDTH+1)'(DEPTH));

  // Combinational read; out-of-range reads return zero, X address stays X
  assign rdata_o = in_range ? mem_q[addr_i] : '0;

  // Next-state of the array: only the addressed in-range word may change
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we_i && (addr_i == ADDR_WIDTH'(i))) begin
        mem_d[i] = wdata_i;
      end
    end
  end

  // Array state with asynchronous clear; reset discards any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sram_sp.sv
// Directed vector bench for sram_sp.
// Covers DEPTH=8 and a non-power-of-two DEPTH=6 instance.
module tb_sram_sp;

  logic        clk;
  logic        rst_n;
  logic [2:0]  addr8;
  logic [31:0] wdata8;
  logic        we8;
  logic [31:0] rdata8;
  logic [2:0]  addr6;
  logic [31:0] wdata6;
  logic        we6;
  logic [31:0] rdata6;

  int n_checks;
  int n_fail;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  vec_t vecs[$];

  sram_sp #(.DATA_WIDTH(32), .DEPTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .addr_i(addr8),
    .wdata_i(wdata8), .we_i(we8), .rdata_o(rdata8)
  );

  sram_sp #(.DATA_WIDTH(32), .DEPTH(6), .ADDR_WIDTH(3)) u6 (
    .clk(clk), .rst_n(rst_n), .addr_i(addr6),
    .wdata_i(wdata6), .we_i(we6), .rdata_o(rdata6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we,
                     input logic [2:0] addr, input logic [31:0] wdata,
                     input logic [31:0] pre, input logic [31:0] post);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_pre = pre; v.exp_post = post;
    vecs.push_back(v);
  endtask

  // drive at negedge, check before and after the next rising edge
  task automatic apply8(input vec_t v);
    @(negedge clk);
    we8 = v.we; addr8 = v.addr; wdata8 = v.wdata;
    #1 check({v.name, "_pre"}, rdata8, v.exp_pre);
    @(posedge clk);
    #1 check({v.name, "_post"}, rdata8, v.exp_post);
  endtask

  task automatic write6(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    we6 = 1'b1; addr6 = a; wdata6 = d;
    @(posedge clk);
    #1 we6 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    we8 = 1'b0; addr8 = '0; wdata8 = '0;
    we6 = 1'b0; addr6 = '0; wdata6 = '0;

    // reset state across all addresses
    for (int i = 0; i < 8; i++) begin
      addr8 = 3'(i);
      #1 check($sformatf("rst_a%0d", i), rdata8, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // async clear between edges
    begin
      vec_t v;
      v.name = "w_beef"; v.we = 1'b1; v.addr = 3'd3;
      v.wdata = 32'hDEADBEEF; v.exp_pre = 32'h0;
      v.exp_post = 32'hDEADBEEF;
      apply8(v);
    end
    we8 = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_clr", rdata8, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr8 = 3'(i);
      #1 check($sformatf("post_rst_a%0d", i), rdata8, 32'h0);
    end

    // vector table
    for (int i = 0; i < 8; i++)
      add($sformatf("wr%0d", i), 1'b1, 3'(i), 32'h11111111 + i,
          32'h0, 32'h11111111 + i);
    for (int i = 0; i < 8; i++)
      add($sformatf("rd%0d", i), 1'b0, 3'(i), 32'h0,
          32'h11111111 + i, 32'h11111111 + i);
    for (int i = 0; i < 4; i++)
      add($sformatf("nowr%0d", i), 1'b0, 3'd2, 32'hFFFFFFFF,
          32'h11111113, 32'h11111113);
    add("pre5", 1'b1, 3'd5, 32'hAAAA0000, 32'h11111116, 32'hAAAA0000);
    add("rdw5", 1'b1, 3'd5, 32'h5555FFFF, 32'hAAAA0000, 32'h5555FFFF);
    add("rd4", 1'b0, 3'd4, 32'h0, 32'h11111115, 32'h11111115);
    add("rd6", 1'b0, 3'd6, 32'h0, 32'h11111117, 32'h11111117);
    add("rd5", 1'b0, 3'd5, 32'h0, 32'h5555FFFF, 32'h5555FFFF);
    foreach (vecs[i]) apply8(vecs[i]);

    // reset collides with a write
    @(negedge clk);
    rst_n = 1'b0; we8 = 1'b1; addr8 = 3'd1; wdata8 = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    we8 = 1'b0; rst_n = 1'b1;
    #1 check("coll_a1", rdata8, 32'h0);
    @(posedge clk);
    #1 check("coll_a1_later", rdata8, 32'h0);

    // non-power-of-two depth
    for (int i = 0; i < 6; i++) write6(3'(i), 32'h100 + i);
    write6(3'd6, 32'hCAFE);
    write6(3'd7, 32'hCAFE);
    for (int i = 0; i < 8; i++) begin
      addr6 = 3'(i);
      #1 check($sformatf("d6_a%0d", i), rdata6,
               (i < 6) ? 32'h100 + i : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
